// File: rtl/order_quantity.sv
// order_quantity: pipelined BASE_QTY * exp(-ETA * inventory_state) order sizing, 5-cycle latency.
// Define ORDER_QTY_VALID_EN to add i_valid/o_valid sample qualification.
module order_quantity (
   input  logic               i_clk,
   input  logic               i_rst,
`ifdef ORDER_QTY_VALID_EN
   input  logic               i_valid,
   output logic               o_valid,
`endif
   input  logic signed [63:0] inventory_state,
   output logic        [63:0] order_out
);
   localparam int FRAC_BITS = 34;
   localparam logic signed [127:0] ETA_Q = 128'sd85899346;
   localparam logic signed [127:0] X_MAX = 128'sd20 <<< FRAC_BITS;
   localparam logic signed [75:0]  LOG2E = 76'sd24785312075;
   localparam logic [47:0]         BASE_QTY = 48'd100;
   // 2^f = sum (ln2)^n/n! * f^n, Q40, degree 8; C0 exactly 1.0
   localparam logic [40:0] C0 = 41'd1099511627776;
   localparam logic [40:0] C1 = 41'd762123384786;
   localparam logic [40:0] C2 = 41'd264131837702;
   localparam logic [40:0] C3 = 41'd61027412866;
   localparam logic [40:0] C4 = 41'd10575244791;
   localparam logic [40:0] C5 = 41'd1466040222;
   localparam logic [40:0] C6 = 41'd169363608;
   localparam logic [40:0] C7 = 41'd16770559;
   localparam logic [40:0] C8 = 41'd1453058;

   function automatic logic [40:0] hstep(input logic [40:0] a, input logic [39:0] f, input logic [40:0] c);
      hstep = c + 41'((82'(a) * 82'(f)) >> 40);
   endfunction

   logic               in_v;
   logic        [4:0]  v_q, v_d;
   logic signed [127:0] xp;
   logic signed [39:0] x_q, x_d, y;
   logic signed [5:0]  k2_q, k3_q, k4_q;
   logic        [33:0] f2_q, f3_q;
   logic        [40:0] acc3_q, acc3_d, p4_q, p4_d;
   logic        [47:0] m;
   logic signed [6:0]  s;
   logic        [69:0] r;
   logic        [63:0] out_q, out_d;

`ifdef ORDER_QTY_VALID_EN
   assign in_v    = i_valid;
   assign o_valid = v_q[4];
`else
   assign in_v = 1'b1;
`endif

   assign xp = -(ETA_Q * inventory_state) >>> FRAC_BITS;
   assign x_d = xp > X_MAX ? 40'(X_MAX) : xp < -X_MAX ? 40'(-X_MAX) : 40'(xp);
   assign y = 40'((x_q * LOG2E) >>> FRAC_BITS);
   assign acc3_d = hstep(hstep(hstep(hstep(C8, {f2_q, 6'd0}, C7), {f2_q, 6'd0}, C6), {f2_q, 6'd0}, C5), {f2_q, 6'd0}, C4);
   assign p4_d = hstep(hstep(hstep(hstep(acc3_q, {f3_q, 6'd0}, C3), {f3_q, 6'd0}, C2), {f3_q, 6'd0}, C1), {f3_q, 6'd0}, C0);
   // p4 is Q40, output is Q34: net shift is k - 6
   assign m = p4_q * BASE_QTY;
   assign s = 7'(k4_q) - 7'sd6;
   assign r = s[6] ? 70'(m >> 7'(-s)) : 70'(m) << s;
   assign out_d = v_q[3] ? (|r[69:64] ? '1 : r[63:0]) : out_q;
   assign v_d = 5'(v_q << 1) | 5'(in_v);
   assign order_out = out_q;

   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         v_q    <= '0;
         x_q    <= '0;
         k2_q   <= '0;
         f2_q   <= '0;
         k3_q   <= '0;
         f3_q   <= '0;
         acc3_q <= '0;
         k4_q   <= '0;
         p4_q   <= '0;
         out_q  <= '0;
      end else begin
         v_q    <= v_d;
         x_q    <= x_d;
         k2_q   <= y[39:34];
         f2_q   <= y[33:0];
         k3_q   <= k2_q;
         f3_q   <= f2_q;
         acc3_q <= acc3_d;
         k4_q   <= k3_q;
         p4_q   <= p4_d;
         out_q  <= out_d;
      end
endmodule

// File: tb/tb_order_quantity.sv
// tb_order_quantity: random and directed stimulus against a real-valued exp() reference model.
module tb_order_quantity;
   logic               i_clk = 1'b0;
   logic               i_rst = 1'b1;
   logic signed [63:0] inventory_state = '0;
   logic        [63:0] order_out;
`ifdef ORDER_QTY_VALID_EN
   logic               i_valid = 1'b0;
   logic               o_valid;
`endif
   int checks = 0;
   int errors = 0;
   logic signed [63:0] hist[$];
   logic               vh[$];
   logic        [63:0] held = '0;
   logic        [63:0] held_tol = '0;

   order_quantity dut (
      .i_clk(i_clk),
      .i_rst(i_rst),
`ifdef ORDER_QTY_VALID_EN
      .i_valid(i_valid),
      .o_valid(o_valid),
`endif
      .inventory_state(inventory_state),
      .order_out(order_out)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp, input logic [63:0] tol);
      logic [63:0] d;
      d = got > exp ? got - exp : exp - got;
      checks++;
      if (d > tol) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
      end
   endtask

   function automatic logic [63:0] to_u64(input real r);
      return r >= 2.0**63 ? {1'b1, 63'(longint'(r - 2.0**63))} : 64'(longint'(r));
   endfunction

   function automatic void model(input logic signed [63:0] inv, output logic [63:0] e, output logic [63:0] tol);
      real x, q;
      x = -(85899346.0 / 2.0**34) * (real'(inv) / 2.0**34);
      x = x > 20.0 ? 20.0 : x < -20.0 ? -20.0 : x;
      q = 100.0 * 2.0**34 * $exp(x);
      if (inv == 0) begin
         e = 64'd100 << 34;
         tol = 0;
      end else if (q >= 2.0**64) begin
         e = '1;
         tol = 0;
      end else begin
         e = to_u64(q);
         tol = to_u64(q / 2.0**20);
         if (tol < 2) tol = 2;
      end
   endfunction

   task automatic compare();
      logic [63:0] e, t;
      logic ev;
      ev = 1'b0;
      if (hist.size() >= 5) ev = vh[vh.size() - 5];
      if (ev) begin
         model(hist[hist.size() - 5], e, t);
         held = e;
         held_tol = t;
      end
`ifdef ORDER_QTY_VALID_EN
      check("o_valid", 64'(o_valid), 64'(ev), 0);
`endif
      check("order_out", order_out, held, held_tol);
   endtask

   task automatic step(input logic signed [63:0] inv, input logic v);
      inventory_state = inv;
`ifdef ORDER_QTY_VALID_EN
      i_valid = v;
      vh.push_back(v);
`else
      vh.push_back(1'b1);
`endif
      @(posedge i_clk);
      hist.push_back(inv);
      @(negedge i_clk);
      compare();
   endtask

   task automatic mid_reset();
      #2 i_rst = 1'b1;
      #1 check("rst_async", order_out, 0, 0);
`ifdef ORDER_QTY_VALID_EN
      check("rst_o_valid", 64'(o_valid), 0, 0);
`endif
      hist.delete();
      vh.delete();
      held = '0;
      held_tol = '0;
      repeat (2) begin
         @(negedge i_clk);
         check("rst_hold", order_out, 0, 0);
      end
      #2 i_rst = 1'b0;
   endtask

   initial begin
      logic [63:0] w;
      logic signed [63:0] inv;
      @(negedge i_clk);
      check("rst_init", order_out, 0, 0);
      @(negedge i_clk);
      #2 i_rst = 1'b0;
      step(64'sd0, 1'b1);
      step(64'sd100 <<< 34, 1'b1);
      step(-(64'sd100 <<< 34), 1'b1);
      step(64'sd0, 1'b1);
      step(64'sd1 <<< 62, 1'b1);
      step(-(64'sd1 <<< 62), 1'b1);
      repeat (6) step(64'sd0, 1'b1);
      step(64'sd100 <<< 34, 1'b1);
      step(-(64'sd100 <<< 34), 1'b1);
      mid_reset();
      for (int i = 0; i < 400; i++) begin
         w = {$urandom, $urandom};
         inv = $signed(w) >>> $urandom_range(1, 40);
         step(inv, $urandom_range(0, 9) < 7);
         if (i == 200) mid_reset();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
